// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU handshake bundle: operands/opcode in, registered result out.
// The hazard/issue logic drives the master side; alu_muldiv is the slave.
interface alu_muldiv_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     busy;

  modport master (
    output flush, in_valid, SrcA, SrcB, Operation,
    input  in_ready, out_valid, ALUResult, busy
  );

  modport slave (
    input  flush, in_valid, SrcA, SrcB, Operation,
    output in_ready, out_valid, ALUResult, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// RV32I/RV32M execute-stage ALU: single-cycle base ops, iterative radix-2
// multiply (shift-add) and restoring divide over operand magnitudes.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]     prod_q, prod_d;
  logic [W-1:0]       opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic [1:0]         sel_q, sel_d;
  logic [W-1:0]       result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic [W-1:0]               a, b;
  logic [OPCODE_LENGTH-1:0]   op;
  logic                       accept;

  assign a      = bus.SrcA;
  assign b      = bus.SrcB;
  assign op     = bus.Operation;
  assign accept = bus.in_valid && (state_q == IDLE) && !bus.flush;

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic [W-1:0]       base_res;

  assign shamt = b[SHAMT_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);

  always_comb begin
    base_res = '0;
    case (op[3:0])
      4'b0000:         base_res = a & b;
      4'b0001:         base_res = a | b;
      4'b0010, 4'b0011: base_res = a + b;
      4'b0100, 4'b1010: base_res[0] = lt_s;
      4'b0101:         base_res = a ^ b;
      4'b0110:         base_res = a - b;
      4'b1000:         base_res[0] = (a == b);
      4'b1001:         base_res[0] = (a != b);
      4'b1011:         base_res[0] = !lt_s;
      4'b1101:         base_res = a << shamt;
      4'b1110:         base_res = a >> shamt;
      4'b1111:         base_res = $signed(a) >>> shamt;
      default:         base_res = '0;
    endcase
  end

  // M-group decode: signedness per operand, then magnitudes for the iterative unit
  logic         is_m, is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0] abs_a, abs_b;
  logic         div_zero, div_ovf, div_special;
  logic [W-1:0] special_res;

  assign is_m   = op[4];
  assign is_mul = is_m && (op[3:2] == 2'b00);
  assign is_div = is_m && (op[3:2] == 2'b01);
  assign a_sgn  = is_mul ? (op[1:0] != 2'b11) : !op[0];
  assign b_sgn  = is_mul ? !op[1] : !op[0];
  assign a_neg  = a_sgn && a[W-1];
  assign b_neg  = b_sgn && b[W-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;

  assign div_zero    = (b == '0);
  assign div_ovf     = !op[0] && (a == MOST_NEG) && (b == '1);
  assign div_special = is_div && (div_zero || div_ovf);
  assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next, mul_fin;
  logic [W:0]     div_sh, div_diff;
  logic [2*W-1:0] div_next;
  logic [W-1:0]   q_mag, r_mag;

  // Multiply: multiplier sits in the low half and is consumed LSB first
  assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[W-1:1]};
  assign mul_fin  = neg_q ? -mul_next : mul_next;

  // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at LSB
  assign div_sh   = prod_q[2*W-1:W-1];
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = div_diff[W] ? {div_sh[W-1:0], prod_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
  assign q_mag    = div_next[W-1:0];
  assign r_mag    = div_next[2*W-1:W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    sel_d       = sel_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = op[1:0];
          cnt_d = '0;
          if (is_mul) begin
            state_d = MUL;
            prod_d  = {{W{1'b0}}, abs_b};
            opnd_d  = abs_a;
            neg_d   = a_neg ^ b_neg;
          end else if (is_div && !div_special) begin
            state_d = DIV;
            prod_d  = {{W{1'b0}}, abs_a};
            opnd_d  = abs_b;
            neg_d   = op[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            result_d    = is_div ? special_res : (is_m ? '0 : base_res);
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          prod_d = mul_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            result_d    = (sel_q == 2'b00) ? mul_fin[W-1:0] : mul_fin[2*W-1:W];
          end
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          prod_d = div_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            if (sel_q[1]) result_d = neg_q ? -r_mag : r_mag;
            else          result_d = neg_q ? -q_mag : q_mag;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      sel_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      sel_q       <= sel_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv at DATA_WIDTH 32 and 16: arithmetic reference model,
// expected-completion scoreboard and per-cycle output compare.
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) bus32 ();
  alu_muldiv_if #(.DATA_WIDTH(16), .OPCODE_LENGTH(5)) bus16 ();

  alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32.slave));
  alu_muldiv #(.DATA_WIDTH(16), .OPCODE_LENGTH(5)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave));

  typedef struct {
    logic [31:0] val;
    int          due;
    bit          has_lit;
    logic [31:0] lit;
  } exp_t;

  exp_t        q32[$];
  exp_t        q16[$];
  int          busy_until[2];
  logic [31:0] exp_last[2];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, id, cyc, got, want);
  endtask

  // Reference: RISC-V semantics evaluated on sign/zero-extended 64-bit values
  function automatic logic [31:0] model(input int w, input logic [4:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        output int lat);
    longint mask = (longint'(1) << w) - 1;
    longint ua   = longint'(a) & mask;
    longint ub   = longint'(b) & mask;
    longint half = longint'(1) << (w - 1);
    longint sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    longint sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    int     sh   = int'(ub % longint'(w));
    bit     ovf  = (sa == -half) && (sb == -1);
    longint r    = 0;
    lat = 1;
    if (!op[4]) begin
      case (op[3:0])
        4'd0: r = ua & ub;
        4'd1: r = ua | ub;
        4'd2, 4'd3: r = ua + ub;
        4'd4, 4'd10: r = (sa < sb) ? 1 : 0;
        4'd5: r = ua ^ ub;
        4'd6: r = ua - ub;
        4'd8: r = (ua == ub) ? 1 : 0;
        4'd9: r = (ua != ub) ? 1 : 0;
        4'd11: r = (sa >= sb) ? 1 : 0;
        4'd13: r = ua << sh;
        4'd14: r = ua >> sh;
        4'd15: r = sa >>> sh;
        default: r = 0;
      endcase
    end else begin
      case (op[3:0])
        4'd0: begin r = sa * sb;         lat = w + 1; end
        4'd1: begin r = (sa * sb) >>> w; lat = w + 1; end
        4'd2: begin r = (sa * ub) >>> w; lat = w + 1; end
        4'd3: begin r = (ua * ub) >> w;  lat = w + 1; end
        4'd4: begin
          if (ub == 0) r = mask;
          else if (ovf) r = ua;
          else begin r = sa / sb; lat = w + 1; end
        end
        4'd5: begin
          if (ub == 0) r = mask;
          else begin r = ua / ub; lat = w + 1; end
        end
        4'd6: begin
          if (ub == 0) r = ua;
          else if (ovf) r = 0;
          else begin r = sa % sb; lat = w + 1; end
        end
        4'd7: begin
          if (ub == 0) r = ua;
          else begin r = ua % ub; lat = w + 1; end
        end
        default: r = 0;
      endcase
    end
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? bus32.in_ready : bus16.in_ready;
  endfunction

  task automatic issue(input int id, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit has_lit, input logic [31:0] lit,
                       output int acc);
    int   w = (id == 0) ? 32 : 16;
    int   lat;
    exp_t e;
    bit   ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy(id)) begin ok = 1'b1; break; end
    end
    chk("ready_wait", id, {31'b0, ok}, 32'd1);
    acc = cyc;
    if (!ok) return;
    if (id == 0) begin
      bus32.in_valid = 1'b1; bus32.Operation = op; bus32.SrcA = a; bus32.SrcB = b;
    end else begin
      bus16.in_valid = 1'b1; bus16.Operation = op; bus16.SrcA = a[15:0]; bus16.SrcB = b[15:0];
    end
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    e.val     = model(w, op, a, b, lat);
    e.due     = cyc + lat - 1;
    e.has_lit = has_lit;
    e.lit     = lit;
    if (id == 0) q32.push_back(e); else q16.push_back(e);
    if (lat > 1) busy_until[id] = cyc + w;
    acc = cyc;
  endtask

  task automatic run(input int id, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit);
    int acc;
    issue(id, op, a, b, 1'b1, lit, acc);
  endtask

  task automatic flush_at(input int id, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc == target) begin ok = 1'b1; break; end
    end
    chk("flush_reach", id, {31'b0, ok}, 32'd1);
    if (id == 0) bus32.flush = 1'b1; else bus16.flush = 1'b1;
    @(posedge clk);
    #1;
    bus32.flush = 1'b0;
    bus16.flush = 1'b0;
    if (id == 0) q32.delete(); else q16.delete();
    busy_until[id] = cyc;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q32.size() == 0 && q16.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain", 0, {31'b0, ok}, 32'd1);
  endtask

  task automatic cmp_one(input int id, input logic ov, input logic [31:0] res,
                         input logic bsy, input logic rd);
    logic bexp = (cyc < busy_until[id]);
    exp_t e;
    bit   hit = 1'b0;
    chk("busy", id, {31'b0, bsy}, {31'b0, bexp});
    chk("in_ready", id, {31'b0, rd}, {31'b0, !bexp});
    if (id == 0 && q32.size() > 0 && q32[0].due == cyc) begin e = q32.pop_front(); hit = 1'b1; end
    if (id == 1 && q16.size() > 0 && q16[0].due == cyc) begin e = q16.pop_front(); hit = 1'b1; end
    if (hit) begin
      chk("out_valid", id, {31'b0, ov}, 32'd1);
      chk("result", id, res, e.val);
      if (e.has_lit) chk("result_lit", id, res, e.lit);
      exp_last[id] = e.val;
    end else begin
      chk("out_valid_idle", id, {31'b0, ov}, 32'd0);
      chk("result_hold", id, res, exp_last[id]);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      cmp_one(0, bus32.out_valid, bus32.ALUResult, bus32.busy, bus32.in_ready);
      cmp_one(1, bus16.out_valid, {16'b0, bus16.ALUResult}, bus16.busy, bus16.in_ready);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    reset = 1'b1;
    busy_until[0] = 0; busy_until[1] = 0;
    exp_last[0] = '0; exp_last[1] = '0;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.SrcA = '0; bus32.SrcB = '0; bus32.Operation = '0;
    bus16.flush = 1'b0; bus16.in_valid = 1'b0; bus16.SrcA = '0; bus16.SrcB = '0; bus16.Operation = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // base group, back to back
    run(0, 5'b00010, 32'd5, 32'd7, 32'd12);
    run(0, 5'b01111, 32'h8000_0000, 32'h24, 32'hF800_0000);
    run(0, 5'b00000, 32'hF0F0, 32'hFF00, 32'hF000);
    run(0, 5'b00001, 32'hF0F0, 32'hFF00, 32'hFFF0);
    run(0, 5'b00101, 32'hF0F0, 32'hFF00, 32'h0FF0);
    run(0, 5'b00110, 32'd3, 32'd5, 32'hFFFF_FFFE);
    run(0, 5'b00011, 32'h1000, 32'd4, 32'h1004);
    run(0, 5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run(0, 5'b00100, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run(0, 5'b01000, 32'd5, 32'd5, 32'd1);
    run(0, 5'b01001, 32'd5, 32'd5, 32'd0);
    run(0, 5'b01010, 32'h8000_0000, 32'd0, 32'd1);
    run(0, 5'b01011, 32'h8000_0000, 32'd0, 32'd0);
    run(0, 5'b01101, 32'd1, 32'd31, 32'h8000_0000);
    run(0, 5'b01110, 32'h8000_0000, 32'd36, 32'h0800_0000);
    run(0, 5'b00111, 32'h12, 32'h34, 32'd0);
    run(0, 5'b01100, 32'h12, 32'h34, 32'd0);
    run(0, 5'b11000, 32'h12, 32'h34, 32'd0);
    run(0, 5'b11111, 32'h12, 32'h34, 32'd0);

    // multiply / divide
    run(0, 5'b10000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run(0, 5'b10011, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002);
    run(0, 5'b10001, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF);
    run(0, 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(0, 5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(0, 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(0, 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(0, 5'b10101, 32'd100, 32'd7, 32'd14);
    run(0, 5'b10111, 32'd100, 32'd7, 32'd2);
    run(0, 5'b10100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run(0, 5'b10110, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run(0, 5'b10101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // divide special cases, single cycle
    run(0, 5'b10100, 32'd10, 32'd0, 32'hFFFF_FFFF);
    run(0, 5'b10111, 32'd10, 32'd0, 32'd10);
    run(0, 5'b10101, 32'd10, 32'd0, 32'hFFFF_FFFF);
    run(0, 5'b10110, 32'd10, 32'd0, 32'd10);
    run(0, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(0, 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // in_valid ignored while busy
    run(0, 5'b10000, 32'd7, 32'd6, 32'd42);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus32.in_valid = 1'b1; bus32.Operation = 5'b00010; bus32.SrcA = 32'd9; bus32.SrcB = 32'd9;
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    drain();

    // flush mid-multiply, then a fresh op
    issue(0, 5'b10000, 32'd123, 32'd456, 1'b0, 32'd0, acc);
    flush_at(0, acc + 10);
    run(0, 5'b00010, 32'd1, 32'd1, 32'd2);

    // flush with in_valid in IDLE: nothing accepted
    @(negedge clk);
    bus32.flush = 1'b1; bus32.in_valid = 1'b1; bus32.Operation = 5'b00010;
    bus32.SrcA = 32'd3; bus32.SrcB = 32'd3;
    @(posedge clk);
    #1;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0;

    // flush coinciding with the final divide iteration
    issue(0, 5'b10101, 32'd100, 32'd7, 1'b0, 32'd0, acc);
    flush_at(0, acc + 31);
    run(0, 5'b00110, 32'd10, 32'd4, 32'd6);

    // asynchronous reset in the middle of a divide
    issue(0, 5'b10100, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, acc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc == acc + 5) break;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", 0, {31'b0, bus32.out_valid}, 32'd0);
    chk("rst_result", 0, bus32.ALUResult, 32'd0);
    chk("rst_busy", 0, {31'b0, bus32.busy}, 32'd0);
    q32.delete(); q16.delete();
    exp_last[0] = '0; exp_last[1] = '0;
    busy_until[0] = 0; busy_until[1] = 0;
    @(negedge clk);
    #2 reset = 1'b0;

    // 16-bit instance
    run(1, 5'b10000, 32'hFFFF, 32'hFFFF, 32'h0001);
    run(1, 5'b10011, 32'hFFFF, 32'hFFFF, 32'hFFFE);
    run(1, 5'b10100, 32'hFFF9, 32'd2, 32'hFFFD);
    run(1, 5'b10110, 32'hFFF9, 32'd2, 32'hFFFF);
    run(1, 5'b10100, 32'h8000, 32'hFFFF, 32'h8000);
    run(1, 5'b00010, 32'hFFFF, 32'd2, 32'h0001);
    run(1, 5'b01111, 32'h8000, 32'h13, 32'hF000);
    run(0, 5'b00010, 32'd20, 32'd22, 32'd42);
    drain();

    done = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised execute-stage ALU: all base RV32I integer ops plus the RV32M multiply/divide ops.
- Base ops complete with a fixed 1-cycle registered latency.
- MUL* and DIV*/REM* run on an iterative radix-2 unit in DATA_WIDTH+1 cycles.
- Sits in the EX stage. The hazard unit stalls IF/ID/EX while busy=1 and flushes the unit via flush on branch redirect.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be ≥8 and a power of 2.
- OPCODE_LENGTH, 5, Operation width; bit 4 selects the M-extension group.
- SHAMT_W, $clog2(DATA_WIDTH), derived; shift amount bits taken from SrcB.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  abort any in-flight op; result discarded.
- in_valid  input  1  SrcA/SrcB/Operation valid this cycle.
- in_ready  output  1  unit can accept; equals (state==IDLE).
- SrcA  input  DATA_WIDTH  operand A / dividend / multiplicand.
- SrcB  input  DATA_WIDTH  operand B / divisor / multiplier / shamt.
- Operation  input  OPCODE_LENGTH  operation select.
- out_valid  output  1  one-cycle pulse; ALUResult valid.
- ALUResult  output  DATA_WIDTH  registered result; holds last value until next completion.
- busy  output  1  high in MUL or DIV state.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, out_valid=0, ALUResult=0, busy=0.
  - Iteration counter and internal registers cleared.
- Opcode map, bit4=0 (base group):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 ADD (JALR target), 0100 SLT (signed), 0101 XOR, 0110 SUB.
  - 1000 EQ, 1001 NE, 1010 LT signed, 1011 GE signed.
  - 1101 SLL, 1110 SRL, 1111 SRA; shift amount = SrcB[SHAMT_W-1:0].
  - 0111 and 1100 produce 0.
- Opcode map, bit4=1 (M group):
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - 11xxx produce 0.
- Accept = in_valid & in_ready & ~flush.
- States: IDLE, MUL, DIV.
- IDLE:
  - On accepting a base op, an M op with 11xxx encoding, or a divide special case: ALUResult registered at the next edge, out_valid=1 for that single cycle, state stays IDLE. Latency 1; back-to-back accepts every cycle allowed.
  - On accepting a MUL* op: latch operands, go to MUL.
  - On accepting a DIV*/REM* op that is not a special case: latch operands, go to DIV.
- MUL: shift-add over the magnitudes with a 2*DATA_WIDTH product register.
  - Signed operands are made absolute at entry; the sign is applied to the product at the end.
  - Runs DATA_WIDTH iterations, one per cycle.
  - On the last iteration: ALUResult = low half (MUL) or high half (MULH/MULHSU/MULHU), out_valid=1, state returns to IDLE.
  - Total latency from accept edge to out_valid = DATA_WIDTH+1 cycles.
- DIV: restoring division on magnitudes.
  - Quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend.
  - Same DATA_WIDTH+1 latency and completion rules as MUL.
- Divide special cases (resolved in IDLE, latency 1):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return SrcA.
  - Signed overflow (SrcA = most-negative value, SrcB = -1): DIV returns SrcA; REM returns 0.
- in_ready=0 and busy=1 throughout MUL/DIV; in_valid is ignored there.
- flush:
  - In MUL/DIV: next state IDLE; no out_valid; ALUResult unchanged.
  - With in_valid in IDLE: nothing accepted; flush wins.
  - In the same cycle as the final iteration: no out_valid.
- Reset asserted mid-operation: immediate return to IDLE with all outputs cleared.
- All arithmetic wraps modulo 2^DATA_WIDTH; no overflow flags.

Test Plan:
- Reset, then ADD A=5, B=7 -> next cycle out_valid=1, ALUResult=12. Follow with SRA A=0x80000000, B=0x24 (shamt 4) on the next cycle -> 0xF8000000.
- MUL A=0xFFFFFFFF (-1), B=3 -> out_valid exactly 33 cycles after accept, ALUResult=0xFFFFFFFD. MULHU with the same operands -> 0x00000002. in_ready=0 for the 32 busy cycles.
- DIV A=-7, B=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU A=100, B=7 -> 14 at latency 33.
- DIV A=10, B=0 -> 0xFFFFFFFF at latency 1. REMU A=10, B=0 -> 10. DIV A=0x80000000, B=-1 -> 0x80000000. REM with the same operands -> 0.
- Accept MUL, assert flush at iteration 10 -> no out_valid; in_ready=1 next cycle; ALUResult keeps its prior value. Then ADD 1+1 -> 2.
- Accept DIV, assert reset mid-op -> out_valid=0, ALUResult=0, busy=0 immediately. Repeat with DATA_WIDTH=16: MUL 0xFFFF×0xFFFF -> 0x0001, latency 17.
